// File: rtl/pair_cfg_loader.sv
// pair_cfg_loader
// Configuration front-end for the two-state "pair" stateful atom.
// Words arrive over a valid/ready port into a shadow bank; a commit copies
// the shadow bank into the active bank only during a packet-free cycle, so
// the atom never sees its configuration change while a packet is in flight.
//
// Word map (shadow bank index == write address):
//   0 .. NUM_CONS-1   constants cons_1 .. cons_NUM_CONS
//   NUM_CONS          ctrl[DATA_W-1:0]
//   NUM_CONS+1        ctrl[CTRL_W-1:DATA_W] taken from data bits [CTRL_W-DATA_W-1:0]
// Any higher address is rejected and raises the sticky error flag.
module pair_cfg_loader #(
    parameter int NUM_CONS = 19,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int CTRL_W   = 56
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i__cfg_valid,
    output logic                         o__cfg_ready,
    input  logic [ADDR_W-1:0]            i__cfg_addr,
    input  logic [DATA_W-1:0]            i__cfg_data,
    input  logic                         i__commit,
    input  logic                         i__pkt_valid,
    input  logic                         i__err_clr,
    output logic [NUM_CONS*DATA_W-1:0]   o__cons_flat,
    output logic [CTRL_W-1:0]            o__ctrl_flat,
    output logic                         o__commit_pending,
    output logic                         o__commit_done,
    output logic                         o__cfg_complete,
    output logic [7:0]                   o__epoch,
    output logic                         o__err
);

    // Total addressable words: constants plus the two control words.
    localparam int NUM_WORDS = NUM_CONS + 2;
    // Width of the control slice carried by the upper control word.
    localparam int CTRL_HI_W = CTRL_W - DATA_W;
    // Index of the two control words inside the shadow bank.
    localparam int CTRL_LO_IDX = NUM_CONS;
    localparam int CTRL_HI_IDX = NUM_CONS + 1;
    // Highest legal write address.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    typedef enum logic {
        ST_LOAD    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;

    // Shadow bank: written by the configuration port.
    logic [DATA_W-1:0]      shadow_reg [NUM_WORDS];
    // Active bank: what the atom actually sees.
    logic [DATA_W-1:0]      active_cons_reg [NUM_CONS];
    logic [CTRL_W-1:0]      active_ctrl_reg;

    // One bit per word, set once that word has been written since reset.
    logic [NUM_WORDS-1:0]   mask_reg;
    logic [NUM_WORDS-1:0]   mask_next;
    logic [NUM_WORDS-1:0]   wr_sel;

    logic                   wr_accept;
    logic                   addr_ok;
    logic                   bad_addr;
    logic                   commit_ok;
    logic                   commit_bad;
    logic                   xfer;

    logic                   err_reg;
    logic                   err_next;
    logic                   done_reg;
    logic [7:0]             epoch_reg;

    // ------------------------------------------------------------------
    // Write-port decode
    // ------------------------------------------------------------------

    // Ready is a pure decode of the state: writes only land while loading.
    assign o__cfg_ready      = (state_reg == ST_LOAD);
    assign o__commit_pending = (state_reg == ST_PENDING);

    assign wr_accept = i__cfg_valid && o__cfg_ready;
    assign addr_ok   = (i__cfg_addr <= LAST_ADDR);
    assign bad_addr  = wr_accept && !addr_ok;

    // Per-word write strobes; an out-of-range address selects nothing.
    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_accept && (i__cfg_addr == ADDR_W'(gi));
        end
    endgenerate

    // Mask as it will be after this edge, so a commit can see a same-cycle write.
    assign mask_next = mask_reg | wr_sel;

    // ------------------------------------------------------------------
    // Commit FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode: accept a commit only on a complete bank, then wait
    // for a cycle with no packet before transferring.
    always_comb begin
        state_next = state_reg;
        commit_ok  = 1'b0;
        commit_bad = 1'b0;
        xfer       = 1'b0;
        case (state_reg)
            ST_LOAD: begin
                if (i__commit) begin
                    if (&mask_next) begin
                        commit_ok  = 1'b1;
                        state_next = ST_PENDING;
                    end else begin
                        commit_bad = 1'b1;
                    end
                end
            end
            ST_PENDING: begin
                if (!i__pkt_valid) begin
                    xfer       = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow bank and written mask
    // ------------------------------------------------------------------

    // Shadow words: each word updates only on its own accepted write.
    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_shadow
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_reg[gi] <= '0;
                end else if (wr_sel[gi]) begin
                    shadow_reg[gi] <= i__cfg_data;
                end
            end
        end
    endgenerate

    // Written mask: only reset ever clears it, so single-word reloads work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_reg <= '0;
        end else begin
            mask_reg <= mask_next;
        end
    end

    assign o__cfg_complete = &mask_reg;

    // ------------------------------------------------------------------
    // Active bank
    // ------------------------------------------------------------------

    // Active constants: copied from the shadow bank only on a transfer.
    generate
        for (genvar gi = 0; gi < NUM_CONS; gi++) begin : g_active_cons
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    active_cons_reg[gi] <= '0;
                end else if (xfer) begin
                    active_cons_reg[gi] <= shadow_reg[gi];
                end
            end
            assign o__cons_flat[gi*DATA_W +: DATA_W] = active_cons_reg[gi];
        end
    endgenerate

    // Active selectors/opcodes: the upper control word contributes only its
    // low CTRL_HI_W bits; the rest of that word is kept but never driven out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_ctrl_reg <= '0;
        end else if (xfer) begin
            active_ctrl_reg <= {shadow_reg[CTRL_HI_IDX][CTRL_HI_W-1:0],
                                shadow_reg[CTRL_LO_IDX]};
        end
    end

    assign o__ctrl_flat = active_ctrl_reg;

    // ------------------------------------------------------------------
    // Status: epoch, done pulse, sticky error
    // ------------------------------------------------------------------

    // Epoch counts completed transfers and wraps; done pulses for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epoch_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= xfer;
            if (xfer) begin
                epoch_reg <= epoch_reg + 8'd1;
            end
        end
    end

    // Error next value: a fresh error beats a simultaneous clear.
    always_comb begin
        err_next = err_reg;
        if (i__err_clr) begin
            err_next = 1'b0;
        end
        if (bad_addr || commit_bad) begin
            err_next = 1'b1;
        end
    end

    // Sticky error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign o__epoch       = epoch_reg;
    assign o__commit_done = done_reg;
    assign o__err         = err_reg;

endmodule

// File: tb/tb_pair_cfg_loader.sv
// tb_pair_cfg_loader
// Table-driven vectors, hand-written corner sequences and random traffic,
// all checked against a word-level model of the loader's rules.
module tb_pair_cfg_loader;

    logic         clk;
    logic         rst_n;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [4:0]   cfg_addr;
    logic [31:0]  cfg_data;
    logic         commit;
    logic         pkt_valid;
    logic         err_clr;
    logic [607:0] cons_flat;
    logic [55:0]  ctrl_flat;
    logic         commit_pending;
    logic         commit_done;
    logic         cfg_complete;
    logic [7:0]   epoch;
    logic         err;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    pair_cfg_loader dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i__cfg_valid     (cfg_valid),
        .o__cfg_ready     (cfg_ready),
        .i__cfg_addr      (cfg_addr),
        .i__cfg_data      (cfg_data),
        .i__commit        (commit),
        .i__pkt_valid     (pkt_valid),
        .i__err_clr       (err_clr),
        .o__cons_flat     (cons_flat),
        .o__ctrl_flat     (ctrl_flat),
        .o__commit_pending(commit_pending),
        .o__commit_done   (commit_done),
        .o__cfg_complete  (cfg_complete),
        .o__epoch         (epoch),
        .o__err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (word level) ----------------
    logic [31:0] m_shadow  [21];
    logic [31:0] m_active  [21];
    bit          m_written [21];
    bit          m_pending;
    bit          m_done;
    bit          m_err;
    int          m_epoch;

    task automatic model_reset();
        for (int k = 0; k < 21; k++) begin
            m_shadow[k]  = '0;
            m_active[k]  = '0;
            m_written[k] = 1'b0;
        end
        m_pending = 1'b0;
        m_done    = 1'b0;
        m_err     = 1'b0;
        m_epoch   = 0;
    endtask

    task automatic model_update(input bit v, input logic [4:0] a, input logic [31:0] d,
                                input bit c, input bit p, input bit e);
        bit nerr;
        bit full;
        nerr = 1'b0;
        full = 1'b1;
        if (v && !m_pending) begin
            if (a <= 5'd20) begin
                m_shadow[a]  = d;
                m_written[a] = 1'b1;
            end else begin
                nerr = 1'b1;
            end
        end
        m_done = 1'b0;
        if (!m_pending) begin
            for (int k = 0; k < 21; k++) full &= m_written[k];
            if (c) begin
                if (full) m_pending = 1'b1;
                else      nerr = 1'b1;
            end
        end else if (!p) begin
            for (int k = 0; k < 21; k++) m_active[k] = m_shadow[k];
            m_epoch   = (m_epoch + 1) % 256;
            m_done    = 1'b1;
            m_pending = 1'b0;
        end
        if (nerr)   m_err = 1'b1;
        else if (e) m_err = 1'b0;
    endtask

    // ---------------- comparison helpers ----------------
    task automatic chk(input string nm, input logic [607:0] act, input logic [607:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic check_model();
        logic [607:0] xc;
        logic [55:0]  xt;
        bit           all;
        all = 1'b1;
        for (int k = 0; k < 19; k++) xc[k*32 +: 32] = m_active[k];
        xt = {m_active[20][23:0], m_active[19]};
        for (int k = 0; k < 21; k++) all &= m_written[k];
        chk("ready",    cfg_ready,      !m_pending);
        chk("pending",  commit_pending, m_pending);
        chk("done",     commit_done,    m_done);
        chk("err",      err,            m_err);
        chk("epoch",    epoch,          m_epoch[7:0]);
        chk("complete", cfg_complete,   all);
        chk("cons",     cons_flat,      xc);
        chk("ctrl",     ctrl_flat,      xt);
    endtask

    // One clock transaction: drive at negedge, model at posedge, check at next negedge.
    task automatic step(input bit v, input logic [4:0] a, input logic [31:0] d,
                        input bit c, input bit p, input bit e);
        cfg_valid = v; cfg_addr = a; cfg_data = d;
        commit = c; pkt_valid = p; err_clr = e;
        @(posedge clk);
        model_update(v, a, d, c, p, e);
        @(negedge clk);
        check_model();
        txn++;
        $display("txn %0d v=%0b a=%0d d=%0h c=%0b p=%0b e=%0b -> rdy=%0b pend=%0b done=%0b err=%0b epoch=%0d",
                 txn, v, a, d, c, p, e, cfg_ready, commit_pending, commit_done, err, epoch);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        cfg_valid = 0; cfg_addr = 0; cfg_data = 0;
        commit = 0; pkt_valid = 0; err_clr = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cons",     cons_flat,      '0);
        chk("rst_ctrl",     ctrl_flat,      '0);
        chk("rst_pending",  commit_pending, 1'b0);
        chk("rst_done",     commit_done,    1'b0);
        chk("rst_complete", cfg_complete,   1'b0);
        chk("rst_epoch",    epoch,          8'd0);
        chk("rst_err",      err,            1'b0);
        chk("rst_ready",    cfg_ready,      1'b1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        $display("txn reset applied");
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          v;
        logic [4:0]  a;
        logic [31:0] d;
        bit          c;
        bit          p;
        bit          e;
        bit          x_ready;
        bit          x_pend;
        bit          x_done;
        bit          x_err;
        logic [7:0]  x_epoch;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input bit v, input logic [4:0] a, input logic [31:0] d,
                        input bit c, input bit p, input bit e,
                        input bit xr, input bit xp, input bit xd, input bit xe,
                        input logic [7:0] xep);
        vec_t t;
        t.v = v; t.a = a; t.d = d; t.c = c; t.p = p; t.e = e;
        t.x_ready = xr; t.x_pend = xp; t.x_done = xd; t.x_err = xe; t.x_epoch = xep;
        vecs.push_back(t);
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_valid = 0; cfg_addr = 0; cfg_data = 0;
        commit = 0; pkt_valid = 0; err_clr = 0;
        model_reset();

        // Full load k -> k+1; last word written together with the commit.
        for (int k = 0; k < 20; k++)
            addv(1, 5'(k), 32'(k + 1), 0, 0, 0,   1, 0, 0, 0, 8'd0);
        addv(1, 5'd20, 32'd21, 1, 0, 0,           0, 1, 0, 0, 8'd0);
        addv(0, 5'd0,  32'd0,  0, 0, 0,           1, 0, 1, 0, 8'd1);
        addv(0, 5'd0,  32'd0,  0, 1, 0,           1, 0, 0, 0, 8'd1);
        // Bad address, clear racing a second bad address, then a clean clear.
        addv(1, 5'd25, 32'hA5A5_A5A5, 0, 0, 0,    1, 0, 0, 1, 8'd1);
        addv(1, 5'd30, 32'h5A5A_5A5A, 0, 0, 1,    1, 0, 0, 1, 8'd1);
        addv(0, 5'd0,  32'd0,  0, 0, 1,           1, 0, 0, 0, 8'd1);
        // Recommit; a write presented while pending is refused.
        addv(0, 5'd0,  32'd0,  1, 0, 0,           0, 1, 0, 0, 8'd1);
        addv(1, 5'd0,  32'd99, 0, 1, 0,           0, 1, 0, 0, 8'd1);
        addv(0, 5'd0,  32'd0,  0, 0, 0,           1, 0, 1, 0, 8'd2);

        @(negedge clk);
        do_reset();

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].c, vecs[i].p, vecs[i].e);
            chk("tbl_ready", cfg_ready,      vecs[i].x_ready);
            chk("tbl_pend",  commit_pending, vecs[i].x_pend);
            chk("tbl_done",  commit_done,    vecs[i].x_done);
            chk("tbl_err",   err,            vecs[i].x_err);
            chk("tbl_epoch", epoch,          vecs[i].x_epoch);
        end
        for (int k = 1; k <= 19; k++)
            chk($sformatf("cons_%0d", k), cons_flat[(k-1)*32 +: 32], 32'(k));
        chk("ctrl_lo",  ctrl_flat[31:0],  32'd20);
        chk("ctrl_hi",  ctrl_flat[55:32], 24'd21);
        chk("complete", cfg_complete,     1'b1);

        // Incomplete commit: word 20 never written.
        do_reset();
        for (int k = 0; k < 20; k++) step(1, 5'(k), 32'h100 + 32'(k), 0, 0, 0);
        step(0, 5'd0, 32'd0, 1, 0, 0);
        chk("inc_err",     err,            1'b1);
        chk("inc_pending", commit_pending, 1'b0);
        chk("inc_cons",    cons_flat,      '0);
        chk("inc_epoch",   epoch,          8'd0);

        // Commit during traffic: finish the load, commit under packets.
        step(1, 5'd20, 32'hFFAB_CDEF, 0, 0, 1);
        step(0, 5'd0, 32'd0, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 5'(i), 32'hDEAD_0000 + 32'(i), 1, 1, 0);
            chk("trf_ready",   cfg_ready,      1'b0);
            chk("trf_pending", commit_pending, 1'b1);
            chk("trf_cons",    cons_flat,      '0);
        end
        step(0, 5'd0, 32'd0, 0, 0, 0);
        chk("trf_done",  commit_done,     1'b1);
        chk("trf_cons1", cons_flat[31:0], 32'h100);
        chk("trf_ctrh",  ctrl_flat[55:32], 24'hAB_CDEF);

        // Epoch wrap: 256 single-word commits from a fresh reset.
        do_reset();
        for (int k = 0; k < 21; k++) step(1, 5'(k), $urandom, 0, 0, 0);
        for (int i = 0; i < 256; i++) begin
            step(1, 5'(i % 21), $urandom, 1, 0, 0);
            step(0, 5'd0, 32'd0, 0, 0, 0);
            if (i == 254) chk("epoch_255", epoch, 8'd255);
        end
        chk("epoch_wrap", epoch, 8'd0);
        step(1, 5'd3, 32'h1234_5678, 1, 0, 0);
        step(0, 5'd0, 32'd0, 0, 0, 0);
        chk("epoch_one", epoch, 8'd1);
        // Reset abort while pending.
        step(1, 5'd4, 32'h0BAD_F00D, 1, 1, 0);
        chk("abort_pending", commit_pending, 1'b1);
        do_reset();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 1) == 1), 5'($urandom_range(0, 23)), $urandom,
                 ($urandom_range(0, 6) == 0), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 19) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
